// File: rtl/vliw_rf_pkg.sv
// Shared constants, address-width helper and default vector types for the
// VLIW register file and its write arbiter.
package vliw_rf_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 16;

  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef logic [addr_w(NUM_REGS_DEF)-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0]           data_t;
endpackage

// File: rtl/vliw_wr_arbiter.sv
// Priority resolution of all write ports against one address: the
// highest-indexed enabled matching port wins; two or more matches is a conflict.
module vliw_wr_arbiter #(
  parameter int NUM_WR = 2,
  parameter int ADDR_W = 4,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0]             addr,
  output logic                          hit,
  output logic [IDX_W-1:0]              win,
  output logic                          conflict
);
  always_comb begin
    hit      = 1'b0;
    win      = '0;
    conflict = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p] && wr_addr[p] == addr) begin
        conflict = conflict | hit;
        hit      = 1'b1;
        win      = IDX_W'(p);
      end
    end
  end
endmodule

// File: rtl/vliw_regfile_sb.sv
// Multi-port register file with per-register busy scoreboard; state updates on
// the falling clock edge, reads and busy lookups are combinational.
module vliw_regfile_sb
  import vliw_rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = addr_w(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0] wr_data,
  input  logic [NUM_WR-1:0]             iss_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0] iss_addr,
  input  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]             rd_busy,
  output logic                          any_busy,
  output logic                          wr_conflict
);
  localparam int IDX_W = (NUM_WR > 1) ? addr_w(NUM_WR) : 1;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs, regs_nxt;
  logic [NUM_REGS-1:0]             busy, busy_nxt;
  logic [NUM_WR-1:0]               wr_en_eff;
  logic [NUM_REGS-1:0]             wr_hit, reg_conflict;
  logic [NUM_REGS-1:0][IDX_W-1:0]  wr_win;

  // Writes to a hardwired r0 vanish before arbitration, so they neither
  // commit, bypass, nor count toward a conflict.
  always_comb begin
    for (int p = 0; p < NUM_WR; p++)
      wr_en_eff[p] = wr_en[p] && !(ZERO_REG != 0 && wr_addr[p] == '0);
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    vliw_wr_arbiter #(.NUM_WR(NUM_WR), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_arb (
      .wr_en(wr_en_eff), .wr_addr(wr_addr), .addr(ADDR_W'(r)),
      .hit(wr_hit[r]), .win(wr_win[r]), .conflict(reg_conflict[r])
    );
  end

  // Writeback clears busy first; a same-cycle issue then re-marks it.
  always_comb begin
    regs_nxt = regs;
    busy_nxt = busy;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (wr_hit[r]) begin
        regs_nxt[r] = wr_data[wr_win[r]];
        busy_nxt[r] = 1'b0;
      end
      for (int p = 0; p < NUM_WR; p++)
        if (iss_en[p] && iss_addr[p] == ADDR_W'(r)) busy_nxt[r] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      regs_nxt[0] = '0;
      busy_nxt[0] = 1'b0;
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      regs        <= '0;
      busy        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      regs        <= regs_nxt;
      busy        <= busy_nxt;
      wr_conflict <= |reg_conflict;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    if (BYPASS != 0) begin : g_byp
      logic             byp_hit;
      logic [IDX_W-1:0] byp_win;
      logic             unused_byp_conflict;
      vliw_wr_arbiter #(.NUM_WR(NUM_WR), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_arb (
        .wr_en(wr_en_eff), .wr_addr(wr_addr), .addr(rd_addr[i]),
        .hit(byp_hit), .win(byp_win), .conflict(unused_byp_conflict)
      );
      // Forwarding is suppressed while reset holds, so reads stay zero.
      assign rd_data[i] = (byp_hit && !reset) ? wr_data[byp_win] : regs[rd_addr[i]];
    end else begin : g_nobyp
      assign rd_data[i] = regs[rd_addr[i]];
    end
    assign rd_busy[i] = busy[rd_addr[i]];
  end

  assign any_busy = |busy;
endmodule

// File: tb/tb_vliw_regfile_sb.sv
// Directed checks of the register file: reset, write priority, bypass on/off,
// scoreboard set/clear ordering and the hardwired zero register.
module tb_vliw_regfile_sb;
  import vliw_rf_pkg::*;

  localparam int NUM_RD = 4;
  localparam int NUM_WR = 2;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_WR-1:0]        wr_en, iss_en;
  addr_t [NUM_WR-1:0]       wr_addr, iss_addr;
  data_t [NUM_WR-1:0]       wr_data;
  addr_t [NUM_RD-1:0]       rd_addr;
  data_t [NUM_RD-1:0]       rd_data, rd_data_nb;
  logic [NUM_RD-1:0]        rd_busy, rd_busy_nb;
  logic                     any_busy, any_busy_nb, wr_conflict, wr_conflict_nb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vliw_regfile_sb #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .any_busy(any_busy), .wr_conflict(wr_conflict)
  );

  vliw_regfile_sb #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .rd_busy(rd_busy_nb), .any_busy(any_busy_nb), .wr_conflict(wr_conflict_nb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Commit on the falling edge, then settle 1 time unit past it.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    iss_en = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    wr_en[p] = 1'b1; wr_addr[p] = addr_t'(a); wr_data[p] = d;
  endtask

  task automatic iss(input int p, input int a);
    iss_en[p] = 1'b1; iss_addr[p] = addr_t'(a);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    wr_addr = '0; wr_data = '0; iss_addr = '0; rd_addr = '0;
    tick(); tick();
    chk("rst_rd_data", rd_data[0], 32'h0);
    chk("rst_any_busy", {31'h0, any_busy}, 32'h0);
    chk("rst_conflict", {31'h0, wr_conflict}, 32'h0);
    reset = 1'b0;
    tick();

    // r5 written and r6 issued, then a half-cycle reset mid-stream
    wr(0, 5, 32'hDEADBEEF); iss(0, 6);
    tick(); idle();
    rd_addr[0] = 4'd5; rd_addr[1] = 4'd6; #1;
    chk("wr_r5", rd_data[0], 32'hDEADBEEF);
    chk("iss_r6_busy", {31'h0, rd_busy[1]}, 32'h1);
    #2;
    wr(0, 5, 32'h1234); iss(1, 5);
    reset = 1'b1; #1;
    chk("midrst_rd_data", rd_data[0], 32'h0);
    chk("midrst_rd_busy", {31'h0, rd_busy[1]}, 32'h0);
    chk("midrst_any_busy", {31'h0, any_busy}, 32'h0);
    #4;
    idle(); reset = 1'b0;
    tick();
    chk("postrst_r5", rd_data[0], 32'h0);

    // same-address conflict: port1 wins, one-cycle conflict pulse
    wr(0, 3, 32'h11); wr(1, 3, 32'h22); rd_addr[1] = 4'd3; #1;
    chk("prio_byp", rd_data[1], 32'h22);
    chk("prio_nobyp_old", rd_data_nb[1], 32'h0);
    tick(); idle(); #1;
    chk("prio_r3", rd_data[1], 32'h22);
    chk("prio_r3_nb", rd_data_nb[1], 32'h22);
    chk("conflict_pulse", {31'h0, wr_conflict}, 32'h1);
    tick();
    chk("conflict_clear", {31'h0, wr_conflict}, 32'h0);

    // bypass vs no bypass on r7 (old value 5)
    wr(0, 7, 32'h5); tick(); idle();
    wr(1, 7, 32'hA5A5); rd_addr[0] = 4'd7; #1;
    chk("byp_same_cycle", rd_data[0], 32'hA5A5);
    chk("nobyp_old", rd_data_nb[0], 32'h5);
    tick(); idle(); #1;
    chk("nobyp_after", rd_data_nb[0], 32'hA5A5);

    // distinct-address writes, no conflict, non-busy writeback stays clear
    wr(0, 10, 32'hAAAA); wr(1, 11, 32'hBBBB); rd_addr[2] = 4'd10; rd_addr[3] = 4'd11;
    tick(); idle(); #1;
    chk("dist_r10", rd_data_nb[2], 32'hAAAA);
    chk("dist_r11", rd_data_nb[3], 32'hBBBB);
    chk("dist_noconf", {31'h0, wr_conflict}, 32'h0);
    chk("dist_notbusy", {31'h0, rd_busy[2]}, 32'h0);

    // RAW on r4
    iss(0, 4); rd_addr[0] = 4'd4;
    tick(); idle(); #1;
    chk("raw_busy", {31'h0, rd_busy[0]}, 32'h1);
    chk("raw_any", {31'h0, any_busy}, 32'h1);
    tick(); tick();
    wr(0, 4, 32'h77); #1;
    chk("raw_noclr_byp", {31'h0, rd_busy[0]}, 32'h1);
    tick(); idle(); #1;
    chk("raw_clear", {31'h0, rd_busy[0]}, 32'h0);
    chk("raw_data", rd_data[0], 32'h77);
    chk("raw_any_clr", {31'h0, any_busy}, 32'h0);

    // simultaneous issue and writeback on busy r9
    iss(0, 9); rd_addr[0] = 4'd9; tick(); idle();
    wr(1, 9, 32'h99); iss(0, 9);
    tick(); idle(); #1;
    chk("iswb_busy", {31'h0, rd_busy[0]}, 32'h1);
    chk("iswb_data", rd_data_nb[0], 32'h99);
    iss(1, 9); tick(); idle(); #1;
    chk("reiss_busy", {31'h0, rd_busy[0]}, 32'h1);
    wr(0, 9, 32'h9A); tick(); idle(); #1;
    chk("single_wb_clr", {31'h0, rd_busy[0]}, 32'h0);

    // zero register
    wr(0, 0, 32'hFFFF); wr(1, 0, 32'hEEEE); iss(0, 0); rd_addr[0] = 4'd0; #1;
    chk("r0_byp", rd_data[0], 32'h0);
    tick(); idle(); #1;
    chk("r0_data", rd_data[0], 32'h0);
    chk("r0_data_nb", rd_data_nb[0], 32'h0);
    chk("r0_busy", {31'h0, rd_busy[0]}, 32'h0);
    chk("r0_any", {31'h0, any_busy}, 32'h0);
    chk("r0_noconf", {31'h0, wr_conflict}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
